// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared definitions for the reset sequencer: sequencer state encoding,
//   the stage-index width helper and the timeout counter width.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  localparam int TIMEOUT_CNT_W = 8;

  // Width of the stage index: clog2 of the domain count, never below 1.
  function automatic int stage_w(input int num_domains);
    return (num_domains <= 2) ? 1 : $clog2(num_domains);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync2.sv
// sync2
//   Two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, clears both flops
//   d      asynchronous input
//   q      input synchronised to clk (two-cycle latency)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  // Stage p0: capture (may go metastable); stage p1: settled copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Releases NUM_DOMAINS active-low resets one at a time, lowest index
//   first. Each domain waits HOLD_CYCLES, then waits for its lock; if the
//   lock does not arrive within LOCK_TIMEOUT cycles the hold is retried.
//   A released domain that loses lock pulls itself and every later domain
//   back into reset. A host soft-reset request restarts the whole sequence.
// Ports:
//   clk_50mhz       free-running management clock
//   rst_50mhz_n     asynchronous active-low reset
//   soft_reset_req  asynchronous level request from host
//   lock_in         per-domain asynchronous lock inputs
//   rst_out_n       per-domain active-low resets (flop outputs)
//   done            high while every domain is released
//   stage           index of the domain currently being sequenced
//   timeout_pulse   one-cycle pulse on each lock timeout
//   timeout_count   saturating count of lock timeouts
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter  int                     NUM_DOMAINS  = 4,
  parameter  int                     HOLD_CYCLES  = 1024,
  parameter  int                     LOCK_TIMEOUT = 65536,
  parameter  logic [NUM_DOMAINS-1:0] LOCK_MASK    = '0,
  parameter  int                     CNT_W        = 17,
  localparam int                     STAGE_W      = stage_w(NUM_DOMAINS)
) (
  input  logic                     clk_50mhz,
  input  logic                     rst_50mhz_n,
  input  logic                     soft_reset_req,
  input  logic [NUM_DOMAINS-1:0]   lock_in,
  output logic [NUM_DOMAINS-1:0]   rst_out_n,
  output logic                     done,
  output logic [STAGE_W-1:0]       stage,
  output logic                     timeout_pulse,
  output logic [TIMEOUT_CNT_W-1:0] timeout_count
);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE   = STAGE_W'(NUM_DOMAINS - 1);

  seq_state_t               state, state_nxt;
  logic [CNT_W-1:0]         count, count_nxt;
  logic [STAGE_W-1:0]       stage_nxt;
  logic [NUM_DOMAINS-1:0]   rst_nxt;
  logic                     done_nxt;
  logic                     pulse_nxt;
  logic [TIMEOUT_CNT_W-1:0] tcnt_nxt;

  logic [NUM_DOMAINS-1:0]   lock_sync;
  logic [NUM_DOMAINS-1:0]   lock_eff;
  logic                     req_sync;

  logic                     loss_found;
  logic [STAGE_W-1:0]       loss_idx;
  logic [NUM_DOMAINS-1:0]   keep_mask;

  // Input synchronisation boundary: everything below uses synced values.
  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_lock_sync
    sync2 u_sync (
      .clk   (clk_50mhz),
      .rst_n (rst_50mhz_n),
      .d     (lock_in[g]),
      .q     (lock_sync[g])
    );
  end

  sync2 u_req_sync (
    .clk   (clk_50mhz),
    .rst_n (rst_50mhz_n),
    .d     (soft_reset_req),
    .q     (req_sync)
  );

  // Masked domains have no meaningful lock source and count as locked.
  assign lock_eff = lock_sync | LOCK_MASK;

  // Lowest released domain that has lost lock; scanning downward lets the
  // lowest index win. keep_mask preserves only domains below it.
  always_comb begin
    loss_found = 1'b0;
    loss_idx   = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (rst_out_n[i] && !lock_eff[i]) begin
        loss_found = 1'b1;
        loss_idx   = STAGE_W'(i);
      end
    end
    keep_mask = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      keep_mask[i] = (i < int'(loss_idx));
    end
  end

  // Next-state and output logic. Soft reset beats lock loss, which beats
  // the normal hold/wait stepping.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    stage_nxt = stage;
    rst_nxt   = rst_out_n;
    done_nxt  = done;
    pulse_nxt = 1'b0;
    tcnt_nxt  = timeout_count;

    if (req_sync) begin
      state_nxt = HOLD;
      count_nxt = '0;
      stage_nxt = '0;
      rst_nxt   = '0;
      done_nxt  = 1'b0;
    end else if (loss_found) begin
      state_nxt = HOLD;
      count_nxt = '0;
      stage_nxt = loss_idx;
      rst_nxt   = rst_out_n & keep_mask;
      done_nxt  = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (count == HOLD_LAST) begin
            state_nxt = WAIT_LOCK;
            count_nxt = '0;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_eff[stage]) begin
            rst_nxt[stage] = 1'b1;
            count_nxt      = '0;
            if (stage == LAST_STAGE) begin
              state_nxt = RUN;
              done_nxt  = 1'b1;
            end else begin
              stage_nxt = stage + 1'b1;
              state_nxt = HOLD;
            end
          end else if (count == TIMEOUT_LAST) begin
            // Retry only touches the current stage; earlier domains keep
            // their released state.
            pulse_nxt = 1'b1;
            if (timeout_count != '1) begin
              tcnt_nxt = timeout_count + 1'b1;
            end
            state_nxt = HOLD;
            count_nxt = '0;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
        RUN: begin
          done_nxt = 1'b1;
        end
        default: begin
          state_nxt = HOLD;
          count_nxt = '0;
        end
      endcase
    end
  end

  // Register boundary: all outputs come straight from these flops.
  always_ff @(posedge clk_50mhz or negedge rst_50mhz_n) begin
    if (!rst_50mhz_n) begin
      state         <= HOLD;
      count         <= '0;
      stage         <= '0;
      rst_out_n     <= '0;
      done          <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      stage         <= stage_nxt;
      rst_out_n     <= rst_nxt;
      done          <= done_nxt;
      timeout_pulse <= pulse_nxt;
      timeout_count <= tcnt_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer (3 domains, hold 16, timeout 64,
//   domain 2 lock masked). A behavioural model built on a single elapsed
//   timer per stage attempt is compared against the DUT every cycle, and a
//   table of hand-computed values at fixed edges pins the model.
module tb_reset_sequencer;

  localparam int              N    = 3;
  localparam int              H    = 16;
  localparam int              T    = 64;
  localparam logic [N-1:0]    MASK = 3'b100;

  localparam int F_RST = 0;
  localparam int F_DONE = 1;
  localparam int F_STAGE = 2;
  localparam int F_PULSE = 3;
  localparam int F_TCNT = 4;

  logic         clk_50mhz = 1'b0;
  logic         rst_50mhz_n = 1'b0;
  logic         soft_reset_req = 1'b0;
  logic [N-1:0] lock_in = 3'b111;
  logic [N-1:0] rst_out_n;
  logic         done;
  logic [1:0]   stage;
  logic         timeout_pulse;
  logic [7:0]   timeout_count;

  int n_cmp = 0;
  int n_fail = 0;
  int edges = 0;

  typedef struct {
    int    edge_n;
    int    field;
    int    exp;
    string name;
  } lit_t;
  lit_t lits[$];

  reset_sequencer #(
    .NUM_DOMAINS  (N),
    .HOLD_CYCLES  (H),
    .LOCK_TIMEOUT (T),
    .LOCK_MASK    (MASK),
    .CNT_W        (17)
  ) dut (
    .clk_50mhz      (clk_50mhz),
    .rst_50mhz_n    (rst_50mhz_n),
    .soft_reset_req (soft_reset_req),
    .lock_in        (lock_in),
    .rst_out_n      (rst_out_n),
    .done           (done),
    .stage          (stage),
    .timeout_pulse  (timeout_pulse),
    .timeout_count  (timeout_count)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  always @(posedge clk_50mhz or negedge rst_50mhz_n) begin
    if (!rst_50mhz_n) edges <= 0;
    else              edges <= edges + 1;
  end

  // Behavioural model: each stage attempt is a timer el; the first H cycles
  // are the hold, after that lock releases the domain, and after H+T cycles
  // without lock the attempt times out and starts over.
  logic [N-1:0] m_rel;
  logic         m_done;
  int           m_stage;
  int           m_el;
  logic         m_pulse;
  int           m_tc;
  logic [N-1:0] lk_d1, lk_d2;
  logic         rq_d1, rq_d2;

  always @(posedge clk_50mhz or negedge rst_50mhz_n) begin : mdl
    logic [N-1:0] lk;
    int           j;
    if (!rst_50mhz_n) begin
      m_rel = '0; m_done = 1'b0; m_stage = 0; m_el = 0; m_pulse = 1'b0; m_tc = 0;
      lk_d1 = '0; lk_d2 = '0; rq_d1 = 1'b0; rq_d2 = 1'b0;
    end else begin
      lk = lk_d2 | MASK;
      j = -1;
      for (int i = N - 1; i >= 0; i--) if (m_rel[i] && !lk[i]) j = i;
      m_pulse = 1'b0;
      if (rq_d2) begin
        m_rel = '0; m_done = 1'b0; m_stage = 0; m_el = 0;
      end else if (j >= 0) begin
        for (int i = j; i < N; i++) m_rel[i] = 1'b0;
        m_done = 1'b0; m_stage = j; m_el = 0;
      end else if (!m_done) begin
        if (m_el >= H && lk[m_stage]) begin
          m_rel[m_stage] = 1'b1;
          if (m_stage == N - 1) m_done = 1'b1;
          else begin m_stage = m_stage + 1; m_el = 0; end
        end else if (m_el == H + T - 1) begin
          m_pulse = 1'b1;
          if (m_tc < 255) m_tc = m_tc + 1;
          m_el = 0;
        end else begin
          m_el = m_el + 1;
        end
      end
      lk_d2 = lk_d1; lk_d1 = lock_in;
      rq_d2 = rq_d1; rq_d1 = soft_reset_req;
    end
  end

  // Single compare process: model check every cycle plus the literal table.
  always @(negedge clk_50mhz) begin : cmp
    int got;
    n_cmp = n_cmp + 1;
    if (rst_out_n !== m_rel || done !== m_done || stage !== 2'(m_stage) ||
        timeout_pulse !== m_pulse || timeout_count !== 8'(m_tc)) begin
      n_fail = n_fail + 1;
      if (n_fail <= 20)
        $display("FAIL model edge=%0d: got rst_out_n=%b done=%b stage=%0d pulse=%b tcnt=%0d, required %b %b %0d %b %0d",
                 edges, rst_out_n, done, stage, timeout_pulse, timeout_count,
                 m_rel, m_done, m_stage, m_pulse, m_tc);
    end
    foreach (lits[k]) begin
      if (lits[k].edge_n == edges) begin
        case (lits[k].field)
          F_RST:   got = int'(rst_out_n);
          F_DONE:  got = int'(done);
          F_STAGE: got = int'(stage);
          F_PULSE: got = int'(timeout_pulse);
          default: got = int'(timeout_count);
        endcase
        n_cmp = n_cmp + 1;
        if ($isunknown({rst_out_n, done, stage, timeout_pulse, timeout_count}) || got != lits[k].exp) begin
          n_fail = n_fail + 1;
          $display("FAIL %s @edge %0d: got %0d required %0d", lits[k].name, edges, got, lits[k].exp);
        end
      end
    end
  end

  task automatic expect_at(input int e, input int f, input int v, input string nm);
    lit_t l;
    l.edge_n = e; l.field = f; l.exp = v; l.name = nm;
    lits.push_back(l);
  endtask

  task automatic expect_reset_state();
    expect_at(0, F_RST, 0, "reset_rst_out_n");
    expect_at(0, F_DONE, 0, "reset_done");
    expect_at(0, F_STAGE, 0, "reset_stage");
    expect_at(0, F_PULSE, 0, "reset_pulse");
    expect_at(0, F_TCNT, 0, "reset_tcnt");
  endtask

  task automatic do_reset(input logic [N-1:0] lk);
    lock_in = lk;
    soft_reset_req = 1'b0;
    rst_50mhz_n = 1'b0;
    repeat (3) @(posedge clk_50mhz);
    #3 rst_50mhz_n = 1'b1;
  endtask

  // Returns 1 time unit after edge n (relative to the last reset release).
  task automatic wait_edge(input int n);
    while (edges < n) begin
      @(posedge clk_50mhz);
      #1;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    // Scenario 1: all locks present from reset.
    lits.delete();
    expect_reset_state();
    expect_at(16, F_RST, 0, "s1_bit0_held");
    expect_at(17, F_RST, 1, "s1_bit0_release");
    expect_at(33, F_RST, 1, "s1_bit1_held");
    expect_at(34, F_RST, 3, "s1_bit1_release");
    expect_at(50, F_DONE, 0, "s1_done_early");
    expect_at(51, F_RST, 7, "s1_bit2_release");
    expect_at(51, F_DONE, 1, "s1_done");
    expect_at(51, F_STAGE, 2, "s1_stage");
    do_reset(3'b111);
    wait_edge(60);

    // Scenarios 2-5 share one reset epoch.
    lits.delete();
    expect_at(17, F_RST, 1, "s2_bit0_release");
    expect_at(96, F_PULSE, 0, "s2_pulse_early");
    expect_at(97, F_PULSE, 1, "s2_timeout1_pulse");
    expect_at(97, F_TCNT, 1, "s2_timeout1_cnt");
    expect_at(97, F_RST, 1, "s2_bit0_kept");
    expect_at(98, F_PULSE, 0, "s2_pulse_one_cycle");
    expect_at(176, F_TCNT, 1, "s2_tcnt_before2");
    expect_at(177, F_TCNT, 2, "s2_timeout2_cnt");
    expect_at(193, F_RST, 1, "s2_bit1_wait");
    expect_at(194, F_RST, 3, "s2_bit1_release");
    expect_at(194, F_STAGE, 2, "s2_stage2");
    expect_at(211, F_RST, 7, "s2_all_released");
    expect_at(211, F_DONE, 1, "s2_done");
    expect_at(222, F_RST, 7, "s3_before_loss");
    expect_at(223, F_RST, 1, "s3_loss_rst");
    expect_at(223, F_DONE, 0, "s3_loss_done");
    expect_at(223, F_STAGE, 1, "s3_loss_stage");
    expect_at(239, F_RST, 1, "s3_rehold");
    expect_at(240, F_RST, 3, "s3_rerelease");
    expect_at(257, F_DONE, 1, "s3_done_again");
    expect_at(262, F_RST, 7, "s4_before_soft");
    expect_at(263, F_RST, 0, "s4_soft_rst");
    expect_at(263, F_STAGE, 0, "s4_soft_stage");
    expect_at(283, F_RST, 0, "s4_hold");
    expect_at(284, F_RST, 1, "s4_bit0_release");
    expect_at(318, F_DONE, 1, "s4_done_again");
    expect_at(332, F_RST, 7, "s5_before");
    expect_at(333, F_RST, 0, "s5_rst");
    expect_at(333, F_STAGE, 0, "s5_stage");
    expect_at(333, F_DONE, 0, "s5_done");
    expect_at(333, F_TCNT, 2, "s5_tcnt_kept");
    expect_at(333, F_PULSE, 0, "s5_no_pulse");
    expect_at(352, F_RST, 1, "s5_bit0_release");
    do_reset(3'b101);
    wait_edge(180);
    lock_in = 3'b111;
    wait_edge(220);
    lock_in = 3'b101;
    wait_edge(221);
    lock_in = 3'b111;
    wait_edge(260);
    soft_reset_req = 1'b1;
    wait_edge(265);
    soft_reset_req = 1'b0;
    wait_edge(330);
    soft_reset_req = 1'b1;
    lock_in = 3'b110;
    wait_edge(333);
    soft_reset_req = 1'b0;
    lock_in = 3'b111;
    wait_edge(360);

    // Scenario 6: masked domain 2 without lock, then domain 1 timeouts saturate.
    lits.delete();
    expect_reset_state();
    expect_at(51, F_RST, 7, "s6_all_released");
    expect_at(51, F_DONE, 1, "s6_done");
    expect_at(63, F_RST, 1, "s6_loss_rst");
    expect_at(63, F_STAGE, 1, "s6_loss_stage");
    expect_at(143, F_TCNT, 1, "s6_first_timeout");
    expect_at(143, F_PULSE, 1, "s6_first_pulse");
    expect_at(20462, F_TCNT, 254, "s6_tcnt_254");
    expect_at(20463, F_TCNT, 255, "s6_tcnt_255");
    expect_at(24063, F_TCNT, 255, "s6_tcnt_saturated");
    expect_at(24063, F_PULSE, 1, "s6_pulse_300");
    expect_at(24063, F_RST, 1, "s6_bit0_kept");
    do_reset(3'b011);
    wait_edge(60);
    lock_in = 3'b001;
    wait_edge(24070);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
